// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer with valid/ready on every channel and
// on the output; selects by Sel (Mode 0) or round-robin arbitration (Mode 1).
module stream_mux_n #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [CHANNELS*WIDTH-1:0] CH,
  input  logic [CHANNELS-1:0]       CH_valid,
  output logic [CHANNELS-1:0]       CH_ready,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      Mode,
  output logic [WIDTH-1:0]          Out,
  output logic                      Out_valid,
  input  logic                      Out_ready,
  output logic [SEL_W-1:0]          Grant
);

  // Handshake: a beat moves on a channel (or on Out) only in a cycle where its
  // valid and ready are both high; the output register reloads when empty or draining.
  logic [SEL_W-1:0] last;
  logic             load;
  logic             cand_found;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] cand_data;

  function automatic int rr_idx(input logic [SEL_W-1:0] from, input int k);
    return (int'(from) + k) % CHANNELS;
  endfunction

  assign load = !Out_valid || Out_ready;

  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    cand_data  = '0;
    if (!Mode) begin
      // An out-of-range Sel matches no channel, so it yields no candidate.
      for (int i = 0; i < CHANNELS; i++) begin
        if (Sel == SEL_W'(i) && CH_valid[i]) begin
          cand_found = 1'b1;
          cand       = SEL_W'(i);
          cand_data  = CH[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        if (!cand_found && CH_valid[rr_idx(last, k)]) begin
          cand_found = 1'b1;
          cand       = SEL_W'(rr_idx(last, k));
          cand_data  = CH[rr_idx(last, k)*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign CH_ready = (Rst_n && load && cand_found) ? (CHANNELS'(1) << cand) : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out       <= '0;
      Out_valid <= 1'b0;
      Grant     <= '0;
      last      <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (cand_found) begin
        Out       <= cand_data;
        Out_valid <= 1'b1;
        Grant     <= cand;
        if (Mode) begin
          last <= cand;
        end
      end else begin
        Out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed scenarios with a scoreboard of expected
// {grant, data} beats, plus a 3-channel instance for the out-of-range select.
module tb_stream_mux_n;

  localparam int W = 10;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] ch;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant;

  logic [23:0] b_ch;
  logic [2:0]  b_valid;
  logic [2:0]  b_ready;
  logic [1:0]  b_sel;
  logic        b_mode;
  logic [7:0]  b_out;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_grant;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  stream_mux_n #(.WIDTH(8), .CHANNELS(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CH(ch), .CH_valid(ch_valid), .CH_ready(ch_ready),
    .Sel(sel), .Mode(mode), .Out(out), .Out_valid(out_valid),
    .Out_ready(out_ready), .Grant(grant)
  );

  stream_mux_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .CH(b_ch), .CH_valid(b_valid), .CH_ready(b_ready),
    .Sel(b_sel), .Mode(b_mode), .Out(b_out), .Out_valid(b_out_valid),
    .Out_ready(b_out_ready), .Grant(b_grant)
  );

  // Clock and watchdog
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ch(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    ch = {d3, d2, d1, d0};
  endtask

  task automatic expect_beat(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  // Scoreboard: every beat the consumer accepts must match the next expectation
  always @(negedge Clk) begin
    if (Rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", {22'd0, grant, out}, 32'hFFFF_FFFF);
      end else begin
        check("sb_beat", {22'd0, grant, out}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    Rst_n = 1'b0;
    mode = 1'b1;
    sel = 2'd0;
    out_ready = 1'b1;
    ch_valid = 4'b1111;
    set_ch(8'h10, 8'h11, 8'h12, 8'h13);
    b_ch = '0;
    b_valid = '0;
    b_sel = '0;
    b_mode = 1'b0;
    b_out_ready = 1'b1;

    // Reset holds everything idle even with all channels valid
    repeat (3) @(posedge Clk);
    #1;
    check("rst_out", {24'd0, out}, 32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'h0);
    check("rst_grant", {30'd0, grant}, 32'h0);
    check("rst_ch_ready", {28'd0, ch_ready}, 32'h0);

    // Round-robin from reset, then with channel 1 dropped
    Rst_n = 1'b1;
    expect_beat(2'd0, 8'h10); expect_beat(2'd1, 8'h11);
    expect_beat(2'd2, 8'h12); expect_beat(2'd3, 8'h13);
    expect_beat(2'd0, 8'h10);
    expect_beat(2'd2, 8'h12); expect_beat(2'd3, 8'h13);
    expect_beat(2'd0, 8'h10); expect_beat(2'd2, 8'h12);
    step();
    check("rr_first_grant", {30'd0, grant}, 32'h0);
    check("rr_first_valid", {31'd0, out_valid}, 32'h1);
    repeat (4) step();
    ch_valid = 4'b1101;
    repeat (4) step();
    ch_valid = 4'b0000;
    step();
    check("rr_drained", {31'd0, out_valid}, 32'h0);

    // Fixed select: only Sel's channel is accepted
    mode = 1'b0;
    sel = 2'd2;
    ch_valid = 4'b1111;
    set_ch(8'h01, 8'h02, 8'hA5, 8'h04);
    #1;
    check("m0_ch_ready", {28'd0, ch_ready}, 32'h4);
    expect_beat(2'd2, 8'hA5);
    step();
    check("m0_out", {24'd0, out}, 32'hA5);
    check("m0_out_valid", {31'd0, out_valid}, 32'h1);
    check("m0_grant", {30'd0, grant}, 32'h2);
    ch_valid = 4'b1011;
    #1;
    check("m0_sel_invalid_ready", {28'd0, ch_ready}, 32'h0);
    step();
    check("m0_empty_valid", {31'd0, out_valid}, 32'h0);
    check("m0_hold_out", {24'd0, out}, 32'hA5);
    check("m0_hold_grant", {30'd0, grant}, 32'h2);

    // Back-pressure holds the beat and blocks every channel
    sel = 2'd0;
    ch_valid = 4'b0001;
    set_ch(8'h3C, 8'h00, 8'h00, 8'h00);
    expect_beat(2'd0, 8'h3C);
    step();
    out_ready = 1'b0;
    set_ch(8'h5A, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ch_ready", {28'd0, ch_ready}, 32'h0);
      step();
      check("bp_out_hold", {24'd0, out}, 32'h3C);
      check("bp_valid_hold", {31'd0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, ch_ready}, 32'h1);
    expect_beat(2'd0, 8'h5A);
    step();
    check("bp_no_gap", {24'd0, out}, 32'h5A);
    ch_valid = 4'b0000;
    step();

    // Round-robin resumes from the pointer left by the last Mode 1 grant (2)
    mode = 1'b1;
    ch_valid = 4'b1111;
    set_ch(8'h20, 8'h21, 8'h22, 8'h23);
    expect_beat(2'd3, 8'h23);
    expect_beat(2'd0, 8'h20);
    repeat (2) step();
    ch_valid = 4'b0000;
    step();

    // Async reset while a beat is held
    ch_valid = 4'b1111;
    out_ready = 1'b0;
    step();
    check("ar_pre_grant", {30'd0, grant}, 32'h1);
    check("ar_pre_valid", {31'd0, out_valid}, 32'h1);
    #3;
    Rst_n = 1'b0;
    #1;
    check("ar_valid_drop", {31'd0, out_valid}, 32'h0);
    check("ar_out_clear", {24'd0, out}, 32'h0);
    check("ar_ch_ready", {28'd0, ch_ready}, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    out_ready = 1'b1;
    expect_beat(2'd0, 8'h20);
    step();
    check("ar_first_grant", {30'd0, grant}, 32'h0);
    ch_valid = 4'b0000;
    step();

    // Three channels, out-of-range select yields no candidate
    b_sel = 2'd1;
    b_valid = 3'b111;
    b_ch = {8'h66, 8'h77, 8'h55};
    step();
    check("c3_out", {24'd0, b_out}, 32'h77);
    check("c3_grant", {30'd0, b_grant}, 32'h1);
    check("c3_valid", {31'd0, b_out_valid}, 32'h1);
    b_sel = 2'd3;
    #1;
    check("c3_oor_ready", {29'd0, b_ready}, 32'h0);
    step();
    check("c3_oor_drain", {31'd0, b_out_valid}, 32'h0);

    check("sb_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshaking on every channel and on the output. It is the successor to the combinational 2:1 channel mux. It adds arbitrary width and channel count, a registered output stage with back-pressure, and two selection modes: externally selected and round-robin arbitrated. It sits on the CPU datapath wherever several producers feed one consumer, such as bus return paths and writeback sources.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, derived localparam = $clog2(CHANNELS), width of Sel and Grant

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- CH  in  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- CH_valid  in  CHANNELS  per-channel data-valid
- CH_ready  out  CHANNELS  per-channel accept strobe, combinational, at most one bit high
- Sel  in  SEL_W  channel index used in Mode 0
- Mode  in  1  0 = fixed select by Sel; 1 = round-robin arbitration
- Out  out  WIDTH  registered output data
- Out_valid  out  1  Out holds a beat
- Out_ready  in  1  consumer accepts the beat
- Grant  out  SEL_W  channel index that supplied the current Out beat

## Operation
- Reset (async, Rst_n=0):
  - Out=0, Out_valid=0, Grant=0.
  - Round-robin pointer Last=CHANNELS-1, so channel 0 has first priority.
  - CH_ready=0 while in reset.
- Load condition: load = !Out_valid || Out_ready. The output register is empty or is draining this cycle.
- Candidate selection (combinational, evaluated every cycle):
  - Mode 0: candidate = Sel.
    - If Sel ≥ CHANNELS, there is no candidate.
    - Candidate is eligible only if CH_valid[Sel]=1.
  - Mode 1: search channels Last+1, Last+2, … with modulo-CHANNELS wrap. Candidate = first channel with CH_valid=1. If no channel is valid, there is no candidate.
- Transfer: when load and an eligible candidate c exists:
  - CH_ready[c]=1 this cycle.
  - At the clock edge: Out ← CH[c], Out_valid ← 1, Grant ← c.
  - In Mode 1 only: Last ← c.
- When load and no eligible candidate: Out_valid ← 0 at the edge. Out and Grant hold their values.
- When not load (Out_valid=1, Out_ready=0):
  - Out, Grant and Out_valid hold.
  - All CH_ready=0.
  - Last holds.
- Channel beats are never dropped or duplicated. A beat transfers on CH only when CH_valid[i] and CH_ready[i] are both 1 in the same cycle.
- Mode switches take effect on the next evaluated load cycle.
  - Last is not modified while in Mode 0.
  - Round-robin resumes from the retained Last after switching back to Mode 1.

## Timing
- Latency: a beat accepted on CH at edge k appears on Out with Out_valid=1 after edge k. It is visible in the cycle k+1.
- Throughput: one beat per cycle when Out_ready is held at 1.
- CH_ready depends combinationally on CH_valid, Sel, Mode, Out_valid and Out_ready. No combinational path exists from CH data to Out.
- Simultaneous drain and fill: Out_ready=1 with a valid candidate replaces the beat at the same edge. There is no bubble.
- Round-robin fairness: with all channels continuously valid and Out_ready=1, grants follow 0,1,…,CHANNELS-1,0,… in successive cycles.
- Reset asserted mid-transfer: Out_valid drops immediately, without waiting for Clk, and the held beat is discarded. After Rst_n rises, the first load occurs at the first rising edge.

## Test plan
- Reset: assert Rst_n=0 with all CH_valid=1 -> Out=0, Out_valid=0, Grant=0, CH_ready=0. Release reset, Mode=1 -> first beat is from channel 0.
- Mode 0 streaming: WIDTH=8, CHANNELS=4, Sel=2, CH2=0xA5 valid, Out_ready=1 -> CH_ready=4'b0100. The next cycle shows Out=0xA5, Out_valid=1, Grant=2. Other channels' valid bits are ignored.
- Back-pressure: with Out holding 0x3C, set Out_ready=0 for 3 cycles while CH0 is valid -> Out stays 0x3C, CH_ready=0. Raise Out_ready -> CH0's beat loads at the next edge with no gap.
- Round-robin: Mode=1, all four channels valid with data 0x10..0x13, Out_ready=1 -> Out sequence 0x10,0x11,0x12,0x13,0x10 and Grant sequence 0,1,2,3,0. Clear CH_valid[1] -> channel 1 is skipped.
- Out-of-range select: CHANNELS=3, Sel=3, Mode=0, all valid -> CH_ready=0. Out_valid falls to 0 after the current beat drains.
- Async reset mid-stream: drop Rst_n between edges while Out_valid=1 -> Out_valid=0 immediately. After release, Last has restarted and channel 0 is granted first.
